// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAMBus command port among N_REQ core requesters,
// with optional fixed priority for requester 0, round-robin otherwise, and a command timeout.
module sdram_arbiter #(
    parameter int N_REQ       = 5,
    parameter int ADDR_W      = 23,
    parameter int DATA_W      = 32,
    parameter int PRIO0_FIXED = 1,
    parameter int TIMEOUT     = 1023
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_enable_mask,
    input  logic [N_REQ-1:0]          req_read,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_writedata,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [N_REQ-1:0]          req_finished,
    output logic                      sdram_read,
    output logic                      sdram_write,
    output logic [ADDR_W-1:0]         sdram_addr,
    output logic [DATA_W-1:0]         sdram_writedata,
    input  logic [DATA_W-1:0]         sdram_readdata,
    input  logic                      sdram_finished,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_busy,
    output logic                      o_timeout
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_ptr, r_idx, w_win;
    logic [CNT_W-1:0]    r_cnt, w_cnt_inc, w_cnt_nxt;
    logic [N_REQ-1:0]    w_valid, w_fin_nxt, w_grant_nxt;
    logic                w_grant, w_done, w_tmo, w_wr_sel, w_rd_nxt, w_wr_nxt, w_tmo_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt, w_rdata_nxt;

    function automatic logic [IDX_W-1:0] wrap(input int v);
        return IDX_W'(v % N_REQ);
    endfunction

    assign w_valid   = (req_read | req_write) & i_enable_mask;
    assign w_cnt_inc = r_cnt + 1'b1;
    // Abort once the command has been on the bus for TIMEOUT cycles without completion
    assign w_tmo     = (r_state == ISSUE) && (w_cnt_inc == CNT_W'(TIMEOUT));
    assign w_grant   = (r_state == IDLE) && (|w_valid);
    assign w_done    = (r_state == ISSUE) && (sdram_finished || w_tmo);

    // Scan downward so the valid index closest above the pointer is the last one written
    always_comb begin
        w_win = '0;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (w_valid[wrap(int'(r_ptr) + k)]) w_win = wrap(int'(r_ptr) + k);
        if (PRIO0_FIXED != 0 && w_valid[0]) w_win = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_valid) w_state_nxt = ISSUE;
            ISSUE:   if (sdram_finished || w_tmo) w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_wr_sel    = req_write[w_win];
        w_rd_nxt    = w_grant ? ~w_wr_sel : (r_state == ISSUE) && !w_done && sdram_read;
        w_wr_nxt    = w_grant ? w_wr_sel : (r_state == ISSUE) && !w_done && sdram_write;
        w_addr_nxt  = w_grant ? req_addr[w_win*ADDR_W +: ADDR_W] : sdram_addr;
        w_wdata_nxt = w_grant ? req_writedata[w_win*DATA_W +: DATA_W] : sdram_writedata;
        w_fin_nxt   = w_done ? N_REQ'(1) << r_idx : '0;
        w_rdata_nxt = !w_done ? req_readdata : !sdram_finished ? '0 : sdram_write ? req_readdata : sdram_readdata;
        w_grant_nxt = w_grant ? N_REQ'(1) << w_win : (r_state == DONE) ? '0 : o_grant;
        w_tmo_nxt   = o_timeout | (w_done & ~sdram_finished);
        w_cnt_nxt   = ((r_state == ISSUE) && !w_done) ? w_cnt_inc : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            r_ptr           <= '0;
            r_idx           <= '0;
            r_cnt           <= '0;
            sdram_read      <= 1'b0;
            sdram_write     <= 1'b0;
            sdram_addr      <= '0;
            sdram_writedata <= '0;
            req_finished    <= '0;
            req_readdata    <= '0;
            o_grant         <= '0;
            o_busy          <= 1'b0;
            o_timeout       <= 1'b0;
        end else begin
            r_ptr           <= w_grant ? ((w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + 1'b1) : r_ptr;
            r_idx           <= w_grant ? w_win : r_idx;
            r_cnt           <= w_cnt_nxt;
            sdram_read      <= w_rd_nxt;
            sdram_write     <= w_wr_nxt;
            sdram_addr      <= w_addr_nxt;
            sdram_writedata <= w_wdata_nxt;
            req_finished    <= w_fin_nxt;
            req_readdata    <= w_rdata_nxt;
            o_grant         <= w_grant_nxt;
            o_busy          <= w_state_nxt != IDLE;
            o_timeout       <= w_tmo_nxt;
        end
endmodule
